// File: rtl/cprv_lsu_stage_if.sv
// Bundle of ex/wb/dmem handshake and payload signals around the LSU stage.
interface cprv_lsu_stage_if #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned IMM_WIDTH  = 32
);
    localparam int unsigned STRB_W = DATA_WIDTH / 8;

    logic                  valid_mem_i;
    logic                  ready_mem_o;
    logic [DATA_WIDTH-1:0] rs1_data_mem_i;
    logic [DATA_WIDTH-1:0] rs2_data_mem_i;
    logic [DATA_WIDTH-1:0] alu_out_mem_i;
    logic [4:0]            rd_addr_mem_i;
    logic                  rd_en_mem_i;
    logic [IMM_WIDTH-1:0]  imm_data_mem_i;
    logic [6:0]            opcode_mem_i;
    logic [2:0]            funct3_mem_i;
    logic [6:0]            funct7_mem_i;
    logic                  mem_w_en_mem_i;

    logic                  valid_wb_o;
    logic                  ready_wb_i;
    logic [DATA_WIDTH-1:0] rs1_data_wb_o;
    logic [DATA_WIDTH-1:0] rs2_data_wb_o;
    logic [DATA_WIDTH-1:0] alu_out_wb_o;
    logic [DATA_WIDTH-1:0] mem_data_wb_o;
    logic [4:0]            rd_addr_wb_o;
    logic                  rd_en_wb_o;
    logic [IMM_WIDTH-1:0]  imm_data_wb_o;
    logic [6:0]            opcode_wb_o;
    logic [2:0]            funct3_wb_o;
    logic [6:0]            funct7_wb_o;
    logic                  w_en_wb_o;
    logic                  misalign_wb_o;

    logic                  valid_dmem_o;
    logic                  ready_dmem_i;
    logic [DATA_WIDTH-1:0] addr_dmem_o;
    logic [DATA_WIDTH-1:0] wdata_dmem_o;
    logic [STRB_W-1:0]     wstrb_dmem_o;
    logic                  w_en_dmem_o;

    logic                  valid_mem_dmem_i;
    logic                  ready_mem_dmem_o;
    logic [DATA_WIDTH-1:0] rdata_dmem_i;

    // LSU side
    modport slave (
        input  valid_mem_i, rs1_data_mem_i, rs2_data_mem_i, alu_out_mem_i, rd_addr_mem_i,
               rd_en_mem_i, imm_data_mem_i, opcode_mem_i, funct3_mem_i, funct7_mem_i,
               mem_w_en_mem_i, ready_wb_i, ready_dmem_i, valid_mem_dmem_i, rdata_dmem_i,
        output ready_mem_o, valid_wb_o, rs1_data_wb_o, rs2_data_wb_o, alu_out_wb_o,
               mem_data_wb_o, rd_addr_wb_o, rd_en_wb_o, imm_data_wb_o, opcode_wb_o,
               funct3_wb_o, funct7_wb_o, w_en_wb_o, misalign_wb_o, valid_dmem_o,
               addr_dmem_o, wdata_dmem_o, wstrb_dmem_o, w_en_dmem_o, ready_mem_dmem_o
    );

    // Pipeline and memory side
    modport master (
        output valid_mem_i, rs1_data_mem_i, rs2_data_mem_i, alu_out_mem_i, rd_addr_mem_i,
               rd_en_mem_i, imm_data_mem_i, opcode_mem_i, funct3_mem_i, funct7_mem_i,
               mem_w_en_mem_i, ready_wb_i, ready_dmem_i, valid_mem_dmem_i, rdata_dmem_i,
        input  ready_mem_o, valid_wb_o, rs1_data_wb_o, rs2_data_wb_o, alu_out_wb_o,
               mem_data_wb_o, rd_addr_wb_o, rd_en_wb_o, imm_data_wb_o, opcode_wb_o,
               funct3_wb_o, funct7_wb_o, w_en_wb_o, misalign_wb_o, valid_dmem_o,
               addr_dmem_o, wdata_dmem_o, wstrb_dmem_o, w_en_dmem_o, ready_mem_dmem_o
    );
endinterface

// File: rtl/cprv_lsu_stage.sv
// In-order load/store stage: tracking FIFO, single dmem request register, load alignment.
module cprv_lsu_stage #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned IMM_WIDTH  = 32,
    parameter int unsigned DEPTH      = 4
) (
    input logic             clk,
    input logic             rst,
    cprv_lsu_stage_if.slave bus
);
    localparam int unsigned STRB_W = DATA_WIDTH / 8;
    localparam int unsigned OFF_W  = $clog2(STRB_W);
    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam logic [6:0]  OP_LOAD  = 7'b0000011;
    localparam logic [6:0]  OP_STORE = 7'b0100011;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] rs1;
        logic [DATA_WIDTH-1:0] rs2;
        logic [DATA_WIDTH-1:0] alu;
        logic [DATA_WIDTH-1:0] mem_data;
        logic [IMM_WIDTH-1:0]  imm;
        logic [4:0]            rd;
        logic                  rd_en;
        logic [6:0]            opcode;
        logic [2:0]            funct3;
        logic [6:0]            funct7;
        logic                  w_en;
        logic                  misalign;
        logic                  done;
    } entry_t;

    entry_t            fifo [DEPTH];
    logic [PTR_W-1:0]  head, tail, rsp_idx;
    logic [CNT_W-1:0]  count, out_cnt;

    logic                  req_valid, req_w_en;
    logic [DATA_WIDTH-1:0] req_addr, req_wdata;
    logic [STRB_W-1:0]     req_wstrb;

    logic                  is_load, is_store, is_mem, illegal, misalign, fault, issue;
    logic [OFF_W-1:0]      off;
    logic [3:0]            nbytes;
    logic [STRB_W-1:0]     strb;
    logic                  wb_valid, pop, push, ready_mem, req_hs, rsp_hs;
    logic [DATA_WIDTH-1:0] ld_shift, ld_data;
    entry_t                new_entry;

    // Decode size, alignment and legality of the incoming instruction
    always_comb begin
        is_load  = (bus.opcode_mem_i == OP_LOAD);
        is_store = (bus.opcode_mem_i == OP_STORE);
        is_mem   = is_load | is_store;
        off      = bus.alu_out_mem_i[OFF_W-1:0];
        nbytes   = 4'd1 << bus.funct3_mem_i[1:0];
        illegal  = (is_load && bus.funct3_mem_i == 3'b111) ||
                   ((DATA_WIDTH == 32) && ((bus.funct3_mem_i[1:0] == 2'b11) ||
                                           (is_load && bus.funct3_mem_i == 3'b110)));
        misalign = (OFF_W'(nbytes - 4'd1) & off) != '0;
        fault    = is_mem & (illegal | misalign);
        issue    = is_mem & ~fault;
        strb     = STRB_W'((32'd1 << nbytes) - 32'd1) << off;

        new_entry          = '0;
        new_entry.rs1      = bus.rs1_data_mem_i;
        new_entry.rs2      = bus.rs2_data_mem_i;
        new_entry.alu      = bus.alu_out_mem_i;
        new_entry.imm      = bus.imm_data_mem_i;
        new_entry.rd       = bus.rd_addr_mem_i;
        new_entry.rd_en    = bus.rd_en_mem_i & ~fault;
        new_entry.opcode   = bus.opcode_mem_i;
        new_entry.funct3   = bus.funct3_mem_i;
        new_entry.funct7   = bus.funct7_mem_i;
        new_entry.w_en     = bus.mem_w_en_mem_i & ~fault;
        new_entry.misalign = fault;
        new_entry.done     = ~issue;
    end

    assign wb_valid  = (count != '0) && fifo[head].done;
    assign pop       = wb_valid & bus.ready_wb_i;
    assign ready_mem = ((count < CNT_W'(DEPTH)) | pop) & (~is_mem | ~req_valid | bus.ready_dmem_i);
    assign push      = bus.valid_mem_i & ready_mem;
    assign req_hs    = req_valid & bus.ready_dmem_i;
    assign rsp_hs    = bus.valid_mem_dmem_i & (out_cnt != '0);

    // Oldest entry still waiting on dmem receives the next response
    always_comb begin
        rsp_idx = '0;
        for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
            if ((CNT_W'(i) < count) && !fifo[head + PTR_W'(i)].done) begin
                rsp_idx = head + PTR_W'(i);
            end
        end
    end

    // Align returned load data by the entry's byte offset, then extend per funct3
    always_comb begin
        ld_shift = bus.rdata_dmem_i >> {fifo[rsp_idx].alu[OFF_W-1:0], 3'b000};
        case (fifo[rsp_idx].funct3)
            3'b000:  ld_data = DATA_WIDTH'($signed(ld_shift[7:0]));
            3'b001:  ld_data = DATA_WIDTH'($signed(ld_shift[15:0]));
            3'b010:  ld_data = DATA_WIDTH'($signed(ld_shift[31:0]));
            3'b100:  ld_data = DATA_WIDTH'(ld_shift[7:0]);
            3'b101:  ld_data = DATA_WIDTH'(ld_shift[15:0]);
            3'b110:  ld_data = DATA_WIDTH'(ld_shift[31:0]);
            default: ld_data = ld_shift;
        endcase
    end

    // Tracking FIFO: push at tail, response completion, pop at head
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) fifo[i] <= '0;
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            out_cnt <= '0;
        end else begin
            if (push) begin
                fifo[tail] <= new_entry;
                tail       <= tail + PTR_W'(1);
            end
            if (rsp_hs) begin
                fifo[rsp_idx].done <= 1'b1;
                if (fifo[rsp_idx].opcode == OP_LOAD) fifo[rsp_idx].mem_data <= ld_data;
            end
            if (pop) head <= head + PTR_W'(1);
            count   <= count + CNT_W'(push) - CNT_W'(pop);
            out_cnt <= out_cnt + CNT_W'(req_hs) - CNT_W'(rsp_hs);
        end
    end

    // dmem request register; holds while the request is stalled
    always_ff @(posedge clk) begin
        if (rst) begin
            req_valid <= 1'b0;
            req_addr  <= '0;
            req_wdata <= '0;
            req_wstrb <= '0;
            req_w_en  <= 1'b0;
        end else if (push && issue) begin
            req_valid <= 1'b1;
            req_addr  <= {bus.alu_out_mem_i[DATA_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
            req_wdata <= is_store ? (bus.rs2_data_mem_i << {off, 3'b000}) : '0;
            req_wstrb <= is_store ? strb : '1;
            req_w_en  <= is_store;
        end else if (bus.ready_dmem_i) begin
            req_valid <= 1'b0;
        end
    end

    assign bus.ready_mem_o      = ready_mem;
    assign bus.ready_mem_dmem_o = (out_cnt != '0);
    assign bus.valid_dmem_o     = req_valid;
    assign bus.addr_dmem_o      = req_addr;
    assign bus.wdata_dmem_o     = req_wdata;
    assign bus.wstrb_dmem_o     = req_wstrb;
    assign bus.w_en_dmem_o      = req_w_en;

    assign bus.valid_wb_o    = wb_valid;
    assign bus.rs1_data_wb_o = fifo[head].rs1;
    assign bus.rs2_data_wb_o = fifo[head].rs2;
    assign bus.alu_out_wb_o  = fifo[head].alu;
    assign bus.mem_data_wb_o = fifo[head].mem_data;
    assign bus.rd_addr_wb_o  = fifo[head].rd;
    assign bus.rd_en_wb_o    = fifo[head].rd_en;
    assign bus.imm_data_wb_o = fifo[head].imm;
    assign bus.opcode_wb_o   = fifo[head].opcode;
    assign bus.funct3_wb_o   = fifo[head].funct3;
    assign bus.funct7_wb_o   = fifo[head].funct7;
    assign bus.w_en_wb_o     = fifo[head].w_en;
    assign bus.misalign_wb_o = fifo[head].misalign;
endmodule

// File: doc/cprv_lsu_stage.md
# cprv_lsu_stage

Parametrised load/store unit that replaces the single-slot memory stage between ex and wb. It tracks up to DEPTH in-order instructions, overlapping dmem requests with outstanding responses. It generates byte strobes and lane-shifted store data, and aligns and extends load data by address offset. Misaligned accesses are flagged to wb and never issued to dmem.

## Interface
- DATA_WIDTH, 64: register/bus width; 32 or 64 only.
- IMM_WIDTH, 32: immediate width passed through.
- DEPTH, 4: tracking FIFO entries (power of two, ≥2); bounds outstanding requests.
- clk  in  1  clock; all state on posedge.
- rst  in  1  reset; synchronous and active-high.
- valid_mem_i / ready_mem_o  in/out  1  ex handshake.
- rs1_data_mem_i, rs2_data_mem_i, alu_out_mem_i  in  DATA_WIDTH  operands; alu_out is the effective address.
- rd_addr_mem_i 5, rd_en_mem_i 1, imm_data_mem_i IMM_WIDTH, opcode_mem_i 7, funct3_mem_i 3, funct7_mem_i 7, mem_w_en_mem_i 1  in  instruction fields.
- valid_wb_o / ready_wb_i  out/in  1  wb handshake.
- rs1/rs2_data_wb_o, alu_out_wb_o, mem_data_wb_o  out  DATA_WIDTH; rd_addr_wb_o 5, rd_en_wb_o 1, imm_data_wb_o, opcode/funct3/funct7_wb_o, w_en_wb_o  out  registered copies.
- misalign_wb_o  out  1  entry is a faulted load/store.
- valid_dmem_o / ready_dmem_i  out/in  1  dmem request handshake.
- addr_dmem_o  out  DATA_WIDTH  address with low log2(DATA_WIDTH/8) bits zeroed.
- wdata_dmem_o  out  DATA_WIDTH; wstrb_dmem_o  out  DATA_WIDTH/8; w_en_dmem_o  out  1.
- valid_mem_dmem_i / ready_mem_dmem_o  in/out  1  dmem response handshake; rdata_dmem_i  in  DATA_WIDTH.

## Operation
- Accept when valid_mem_i & ready_mem_o. The instruction is written to the FIFO tail with done=1 for non-memory ops and faulted accesses, and done=0 for LOAD/STORE issued to dmem.
- ready_mem_o = (count<DEPTH | wb pop this cycle) & (non-memory op | ~valid_dmem_o | ready_dmem_i).
- Size from funct3[1:0]: 1/2/4/8 bytes. Offset is the address's low bits. Misaligned means offset % size ≠ 0.
- Illegal: funct3 LD/SD/LWU when DATA_WIDTH=32, or load funct3 3'b111. Illegal accesses are treated as misaligned.
- Faulted entries: no dmem request; misalign_wb_o=1; rd_en_wb_o=0; w_en_wb_o=0.
- Store request: wstrb = ((1<<size)-1)<<offset; wdata = rs2<<(8*offset); w_en=1.
- Load request: wstrb all ones; w_en=0.
- The dmem request register holds fields stable while valid_dmem_o & ~ready_dmem_i.
- Every issued request, load or store, returns exactly one response, in order.
- ready_mem_dmem_o = 1 when any entry is issued and awaiting a response. A response fills the oldest such entry and sets done.
- On a response, loads get mem_data = rdata>>(8*offset), then sign- or zero-extension per funct3 (LB/LH/LW/LBU/LHU/LWU/LD). Store responses only set done.
- A response with no awaiting entry is not accepted (ready low).
- valid_wb_o = head valid & head done. The entry pops on valid_wb_o & ready_wb_i.
- Count updates on push, pop, or both simultaneously. Pointers wrap modulo DEPTH.

## Timing
- Reset: valid_wb_o=0, valid_dmem_o=0, ready_mem_dmem_o=0; all data/field outputs 0; FIFO empty, pointers 0. ready_mem_o=1 on the first cycle after reset.
- Reset mid-operation discards all entries and pending requests. Later responses to discarded requests are not accepted.
- Non-memory op accepted in cycle N to empty FIFO: valid_wb_o in N+1.
- Load accepted in N: valid_dmem_o in N+1. With ready_dmem_i in N+1 and the response in N+2, valid_wb_o is in N+3.
- Store latency equals load latency (waits for the ack).
- Full FIFO with a simultaneous wb pop: accept allowed in the same cycle.
- Back-to-back requests: one per cycle when ready_dmem_i stays high.
- wb outputs stay stable while valid_wb_o & ~ready_wb_i.
- Order to wb is strictly program order. A non-memory op behind a pending load waits.

## Test plan
- Reset, then ADD rd=5 with alu_out=0x1234 -> valid_wb_o one cycle later, alu_out_wb_o=0x1234, misalign_wb_o=0.
- SH with addr=0x1006, rs2=0xABCD -> addr_dmem_o=0x1000, wstrb=0xC0, wdata=0xABCD<<48, w_en=1. valid_wb_o comes after the ack.
- LB at addr 0x03 with rdata=0x0000_0000_8000_0000 -> mem_data_wb_o=0xFFFF_FFFF_FFFF_FF80. LBU at the same address -> 0x80.
- LW at addr 0x2 -> no valid_dmem_o; misalign_wb_o=1, rd_en_wb_o=0, and this is the next cycle.
- DEPTH=4: issue 4 loads with responses withheld -> ready_mem_o=0 on the 5th. Return 4 responses 3 cycles apart with ready_wb_i held low, then release -> 4 in-order writebacks with correct data.
- ready_dmem_i low for 3 cycles mid-stream -> request fields held. Assert rst during the stall -> all valids 0 next cycle and the FIFO empty.
